// File: rtl/nr_divider_seq.sv
// rtl/nr_divider_seq.sv - sequential radix-2 non-restoring signed/unsigned integer divider
// Optional macro DIV_EARLY_OUT_EN: trivial ops (x/0, 0/x, MIN/-1) skip the iteration.
module nr_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             start_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_q;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;
  logic             ovf_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dzo_q;
  logic             valid_q;

  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic             dz_d;
  logic             ovf_d;
  logic [WIDTH:0]   r_sh_d;
  logic [WIDTH:0]   r_step_d;
  logic [WIDTH-1:0] q_step_d;
  logic [WIDTH:0]   r_fix_d;
  logic [WIDTH-1:0] rem_mag_d;
  logic [WIDTH-1:0] fix_quo_d;
  logic [WIDTH-1:0] fix_rem_d;

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = valid_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dzo_q;

  always_comb begin
    a_neg_d = signed_i & dividend_i[WIDTH-1];
    b_neg_d = signed_i & divisor_i[WIDTH-1];
    a_mag_d = a_neg_d ? -dividend_i : dividend_i;
    b_mag_d = b_neg_d ? -divisor_i : divisor_i;
    dz_d    = (divisor_i == '0);
    ovf_d   = signed_i & (dividend_i == MIN_NEG) & (divisor_i == '1);
  end

  // Add/subtract choice uses the pre-shift sign; the W+1-bit result is exact modulo 2^(W+1).
  always_comb begin
    r_sh_d   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_step_d = r_q[WIDTH] ? (r_sh_d + {1'b0, b_q}) : (r_sh_d - {1'b0, b_q});
    q_step_d = {q_q[WIDTH-2:0], ~r_step_d[WIDTH]};
  end

  always_comb begin
    r_fix_d   = r_q[WIDTH] ? (r_q + {1'b0, b_q}) : r_q;
    rem_mag_d = r_fix_d[WIDTH-1:0];
    fix_quo_d = (sa_q ^ sb_q) ? -q_q : q_q;
    fix_rem_d = sa_q ? -rem_mag_d : rem_mag_d;
    if (dz_q) begin
      fix_quo_d = '1;
      fix_rem_d = a_q;
    end else if (ovf_q) begin
      fix_quo_d = a_q;
      fix_rem_d = '0;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  logic             early_d;
  logic [WIDTH-1:0] early_quo_d;
  logic [WIDTH-1:0] early_rem_d;

  always_comb begin
    early_d     = dz_d | ovf_d | (dividend_i == '0);
    early_quo_d = '0;
    early_rem_d = '0;
    if (dz_d) begin
      early_quo_d = '1;
      early_rem_d = dividend_i;
    end else if (ovf_d) begin
      early_quo_d = dividend_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q   <= dividend_i;
            b_q   <= b_mag_d;
            q_q   <= a_mag_d;
            r_q   <= '0;
            sa_q  <= a_neg_d;
            sb_q  <= b_neg_d;
            dz_q  <= dz_d;
            ovf_q <= ovf_d;
            cnt_q <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
            if (early_d) begin
              quo_q   <= early_quo_d;
              rem_q   <= early_rem_d;
              dzo_q   <= dz_d;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_BUSY;
            end
`else
            state_q <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          r_q <= r_step_d;
          q_q <= q_step_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          quo_q   <= fix_quo_d;
          rem_q   <= fix_rem_d;
          dzo_q   <= dz_q;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divider_seq.sv
// tb/tb_nr_divider_seq.sv - scoreboard bench for nr_divider_seq (WIDTH=32)
// Reference results come from native integer division; a monitor checks each result handshake.
module tb_nr_divider_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic         start_i = 1'b0;
  logic         in_ready_o;
  logic         signed_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;
  logic         busy_o;

  nr_divider_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .start_i    (start_i),
    .in_ready_o (in_ready_o),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .div_zero_o (div_zero_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output exp_t e, output int lat);
    longint sa;
    longint sb;
    bit     ovf;
    bit     early;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    e.dz = (b == 0);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else if (ovf) begin
      e.q = a;
      e.r = '0;
    end else if (sgn) begin
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    early = (b == 0) || (a == 0) || ovf;
`ifdef DIV_EARLY_OUT_EN
    lat = early ? 1 : W + 2;
`else
    lat = early ? W + 2 : W + 2;
`endif
  endfunction

  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected no result", quotient_o, remainder_o);
      end else begin
        e_mon = sbq.pop_front();
        chk("quotient", quotient_o, e_mon.q);
        chk("remainder", remainder_o, e_mon.r);
        chk("div_zero", div_zero_o, e_mon.dz);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_o) chk("in_ready_timeout", in_ready_o, 1);
  endtask

  task automatic do_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    exp_t e;
    int   lat;
    int   n;
    wait_ready();
    ref_div(sgn, a, b, e, lat);
    sbq.push_back(e);
    out_ready_i = (stall == 0);
    signed_i    = sgn;
    dividend_i  = a;
    divisor_i   = b;
    start_i     = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    signed_i   = 1'($urandom);
    dividend_i = $urandom;
    divisor_i  = $urandom;
    n = 1;
    if (lat > 1) chk("busy_after_accept", {busy_o, in_ready_o}, 2'b10);
    while (!out_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", out_valid_o, 1);
    end
    out_ready_i = 1'b1;
  endtask

  task automatic accept_only(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    signed_i   = 1'b0;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_valid_o, quotient_o, remainder_o, div_zero_o, busy_o, in_ready_o},
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b0, 32'h1234_5678, 32'h0, 0);
    do_op(1'b1, 32'h1234_5678, 32'h0, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 32'h0, 32'd5, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // Backpressure: result must hold and a pending start must be ignored.
    begin
      exp_t e;
      int   lat;
      int   n;
      wait_ready();
      ref_div(1'b0, 32'd100, 32'd7, e, lat);
      sbq.push_back(e);
      out_ready_i = 1'b0;
      signed_i    = 1'b0;
      dividend_i  = 32'd100;
      divisor_i   = 32'd7;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 1;
      while (!out_valid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp_latency", n, lat);
      dividend_i = 32'd50;
      divisor_i  = 32'd5;
      start_i    = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_hold", {out_valid_o, in_ready_o, quotient_o, remainder_o}, {1'b1, 1'b0, 32'd14, 32'd2});
      end
      start_i     = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_no_extra_accept", {busy_o, out_valid_o}, 2'b00);
    end

    // Flush during the fifth BUSY cycle.
    accept_only(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_idle", {busy_o, in_ready_o, out_valid_o}, 3'b010);
    repeat (40) @(negedge clk);
    chk("flush_no_result", out_valid_o, 0);
    do_op(1'b0, 32'd9, 32'd3, 0);

    // start_i together with flush_i is not accepted.
    wait_ready();
    dividend_i = 32'd20;
    divisor_i  = 32'd4;
    start_i    = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_start_ignored", {busy_o, in_ready_o}, 2'b01);

    // Asynchronous reset mid-operation.
    accept_only(32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid_o, quotient_o, remainder_o, div_zero_o, busy_o, in_ready_o},
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           s;
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = '0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(1, 15);
        4: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      do_op(s, a, b, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
